eth_tx_arbiter: RTL and testbench

//  Packet-granular round-robin arbiter sharing the single Ethernet TX AXI-Stream
//  (8-bit data, 12-bit tuser payload length) between NUM_SRC requesters.

---
 rtl/eth_tx_arbiter.sv | 154 +++++++++++++++
 tb/tb_eth_tx_arbiter.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/eth_tx_arbiter.sv
// Packet-granular round-robin arbiter that shares one 8-bit Ethernet TX AXI-Stream
// between NUM_SRC producers and enforces an inter-packet gap after every tlast.
module eth_tx_arbiter #(
    parameter int NUM_SRC    = 2,
    parameter int USER_W     = 12,
    parameter int GAP_CYCLES = 4
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic [NUM_SRC-1:0]          s_axis_tvalid_i,
    input  logic [8*NUM_SRC-1:0]        s_axis_tdata_i,
    input  logic [NUM_SRC-1:0]          s_axis_tlast_i,
    input  logic [USER_W*NUM_SRC-1:0]   s_axis_tuser_i,
    output logic [NUM_SRC-1:0]          s_axis_tready_o,
    output logic                        m_axis_tvalid_o,
    output logic [7:0]                  m_axis_tdata_o,
    output logic                        m_axis_tlast_o,
    output logic [USER_W-1:0]           m_axis_tuser_o,
    input  logic                        m_axis_tready_i,
    output logic [$clog2(NUM_SRC)-1:0]  grant_o,
    output logic                        busy_o
);

    localparam int DATA_W = 8;
    localparam int GNT_W  = $clog2(NUM_SRC);
    localparam int GAP_W  = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES + 1) : 1;

    localparam logic [GNT_W-1:0] PTR_RST  = GNT_W'(NUM_SRC - 1);
    localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(GAP_CYCLES);
    localparam logic [GAP_W-1:0] GAP_ONE  = GAP_W'(1'b1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PASS = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    state_t             state_r, state_s;
    logic [GNT_W-1:0]   grant_r, grant_s;
    logic [GNT_W-1:0]   ptr_r, ptr_s;
    logic [GAP_W-1:0]   gap_cnt_r, gap_cnt_s;

    logic [DATA_W-1:0]  src_data_s [NUM_SRC];
    logic [USER_W-1:0]  src_user_s [NUM_SRC];
    logic               sel_valid_s;
    logic               sel_last_s;
    logic               beat_done_s;

    // First requester after ptr, scanning ptr+1, ptr+2, ... modulo NUM_SRC.
    function automatic logic [GNT_W-1:0] rr_pick(
        input logic [NUM_SRC-1:0] req,
        input logic [GNT_W-1:0]   ptr
    );
        logic [GNT_W-1:0] pick;
        logic             found;
        int               idx;
        pick  = ptr;
        found = 1'b0;
        for (int i = 1; i <= NUM_SRC; i++) begin
            idx = (int'(ptr) + i) % NUM_SRC;
            if (!found && req[idx[GNT_W-1:0]]) begin
                pick  = idx[GNT_W-1:0];
                found = 1'b1;
            end else begin
                pick  = pick;
            end
        end
        return pick;
    endfunction

    for (genvar k = 0; k < NUM_SRC; k++) begin : g_src
        assign src_data_s[k] = s_axis_tdata_i[DATA_W*k +: DATA_W];
        assign src_user_s[k] = s_axis_tuser_i[USER_W*k +: USER_W];
    end

    assign sel_valid_s = s_axis_tvalid_i[grant_r];
    assign sel_last_s  = s_axis_tlast_i[grant_r];
    assign beat_done_s = sel_valid_s & m_axis_tready_i;
    assign grant_o     = grant_r;

    // Next-state decision and the zero-latency pass-through mux of the granted source.
    always_comb begin
        state_s         = state_r;
        grant_s         = grant_r;
        ptr_s           = ptr_r;
        gap_cnt_s       = gap_cnt_r;
        s_axis_tready_o = {NUM_SRC{1'b0}};
        m_axis_tvalid_o = 1'b0;
        m_axis_tdata_o  = {DATA_W{1'b0}};
        m_axis_tlast_o  = 1'b0;
        m_axis_tuser_o  = {USER_W{1'b0}};
        busy_o          = (state_r == ST_PASS) || (state_r == ST_GAP);

        case (state_r)
            ST_IDLE: begin
                if (|s_axis_tvalid_i) begin
                    grant_s = rr_pick(s_axis_tvalid_i, ptr_r);
                    state_s = ST_PASS;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_PASS: begin
                m_axis_tvalid_o          = sel_valid_s;
                m_axis_tdata_o           = src_data_s[grant_r];
                m_axis_tlast_o           = sel_last_s;
                m_axis_tuser_o           = src_user_s[grant_r];
                s_axis_tready_o[grant_r] = m_axis_tready_i;
                if (beat_done_s && sel_last_s) begin
                    ptr_s = grant_r;
                    if (GAP_CYCLES == 0) begin
                        state_s   = ST_IDLE;
                        gap_cnt_s = {GAP_W{1'b0}};
                    end else begin
                        state_s   = ST_GAP;
                        gap_cnt_s = GAP_LOAD;
                    end
                end else begin
                    state_s = ST_PASS;
                end
            end
            ST_GAP: begin
                // A zero count can only come from corruption; leave GAP rather than wrap.
                if (gap_cnt_r <= GAP_ONE) begin
                    state_s   = ST_IDLE;
                    gap_cnt_s = {GAP_W{1'b0}};
                end else begin
                    state_s   = ST_GAP;
                    gap_cnt_s = gap_cnt_r - GAP_ONE;
                end
            end
            default: begin
                state_s   = ST_IDLE;
                gap_cnt_s = {GAP_W{1'b0}};
            end
        endcase
    end

    // State, grant, round-robin pointer and gap counter registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_r   <= ST_IDLE;
            grant_r   <= {GNT_W{1'b0}};
            ptr_r     <= PTR_RST;
            gap_cnt_r <= {GAP_W{1'b0}};
        end else begin
            state_r   <= state_s;
            grant_r   <= grant_s;
            ptr_r     <= ptr_s;
            gap_cnt_r <= gap_cnt_s;
        end
    end

endmodule

// File: tb/tb_eth_tx_arbiter.sv
// Self-checking bench for eth_tx_arbiter: vector table, directed corner sequences,
// and randomized packets checked against a packet-level round-robin model.
module tb_eth_tx_arbiter;

    localparam int NSRC = 2;
    localparam int UW   = 12;
    localparam int GAP  = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst;
    logic [1:0]       s_tvalid, s_tlast, s_tready;
    logic [15:0]      s_tdata;
    logic [23:0]      s_tuser;
    logic             m_tvalid, m_tlast, m_tready, grant, busy;
    logic [7:0]       m_tdata;
    logic [11:0]      m_tuser;

    logic [1:0]       g0_tvalid, g0_tlast, g0_tready;
    logic [15:0]      g0_tdata;
    logic [23:0]      g0_tuser;
    logic             g0_mvalid, g0_mlast, g0_mready, g0_grant, g0_busy;
    logic [7:0]       g0_mdata;
    logic [11:0]      g0_muser;

    eth_tx_arbiter #(.NUM_SRC(NSRC), .USER_W(UW), .GAP_CYCLES(GAP)) dut (
        .clk_i(clk), .rst_i(rst),
        .s_axis_tvalid_i(s_tvalid), .s_axis_tdata_i(s_tdata), .s_axis_tlast_i(s_tlast),
        .s_axis_tuser_i(s_tuser), .s_axis_tready_o(s_tready),
        .m_axis_tvalid_o(m_tvalid), .m_axis_tdata_o(m_tdata), .m_axis_tlast_o(m_tlast),
        .m_axis_tuser_o(m_tuser), .m_axis_tready_i(m_tready),
        .grant_o(grant), .busy_o(busy)
    );

    eth_tx_arbiter #(.NUM_SRC(NSRC), .USER_W(UW), .GAP_CYCLES(0)) dut_g0 (
        .clk_i(clk), .rst_i(rst),
        .s_axis_tvalid_i(g0_tvalid), .s_axis_tdata_i(g0_tdata), .s_axis_tlast_i(g0_tlast),
        .s_axis_tuser_i(g0_tuser), .s_axis_tready_o(g0_tready),
        .m_axis_tvalid_o(g0_mvalid), .m_axis_tdata_o(g0_mdata), .m_axis_tlast_o(g0_mlast),
        .m_axis_tuser_o(g0_muser), .m_axis_tready_i(g0_mready),
        .grant_o(g0_grant), .busy_o(g0_busy)
    );

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        s_tvalid = 2'b00; s_tlast = 2'b00; s_tdata = 16'h0; s_tuser = 24'h0; m_tready = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    typedef struct {
        logic [1:0] v; logic [7:0] d0; logic [7:0] d1; logic [1:0] l;
        logic [11:0] u0; logic [11:0] u1; logic mr;
        logic ev; logic [7:0] ed; logic el; logic [11:0] eu; logic [1:0] er; logic eg; logic eb;
    } vec_t;
    vec_t tbl [11];

    typedef struct { int src; logic [7:0] d; logic l; logic [11:0] u; } beat_t;
    beat_t exp_q [$];

    logic [7:0] pd [2][8][16];
    int  plen [2][8];
    int  npkt [2];
    int  cp [2], cb [2], rem [2];
    bit  vl [2], xfer [2];

    task automatic drive_src();
        for (int k = 0; k < NSRC; k++) begin
            if (cp[k] < npkt[k]) begin
                s_tvalid[k]         = vl[k];
                s_tdata[8*k +: 8]   = pd[k][cp[k]][cb[k]];
                s_tlast[k]          = (cb[k] == plen[k][cp[k]] - 1);
                s_tuser[12*k +: 12] = 12'(plen[k][cp[k]]);
            end else begin
                s_tvalid[k] = 1'b0;
            end
        end
    endtask

    initial begin
        int idle, last, s, gap_n;
        bit found, tracking;
        beat_t e;

        rst = 1'b1;
        s_tvalid = 2'b11; s_tlast = 2'b11; s_tdata = 16'h5A5A; s_tuser = 24'h00F00F; m_tready = 1'b1;
        g0_tvalid = 2'b00; g0_tlast = 2'b00; g0_tdata = 16'h0; g0_tuser = 24'h0; g0_mready = 1'b0;

        // ---- reset values while requests are pending ----
        repeat (2) @(posedge clk);
        #1;
        chk("rst m_tvalid", 32'(m_tvalid), 32'd0);
        chk("rst s_tready", 32'(s_tready), 32'd0);
        chk("rst m_tdata",  32'(m_tdata),  32'd0);
        chk("rst m_tlast",  32'(m_tlast),  32'd0);
        chk("rst m_tuser",  32'(m_tuser),  32'd0);
        chk("rst grant",    32'(grant),    32'd0);
        chk("rst busy",     32'(busy),     32'd0);

        // ---- vector table: 3-beat packet, gap, then src1 single beat ----
        tbl[0]  = '{2'b01, 8'hAA, 8'h00, 2'b00, 12'd3, 12'd0, 1'b1, 1'b0, 8'h00, 1'b0, 12'd0, 2'b00, 1'b0, 1'b0};
        tbl[1]  = '{2'b01, 8'hAA, 8'h00, 2'b00, 12'd3, 12'd0, 1'b1, 1'b1, 8'hAA, 1'b0, 12'd3, 2'b01, 1'b0, 1'b1};
        tbl[2]  = '{2'b01, 8'hBB, 8'h00, 2'b00, 12'd3, 12'd0, 1'b1, 1'b1, 8'hBB, 1'b0, 12'd3, 2'b01, 1'b0, 1'b1};
        tbl[3]  = '{2'b01, 8'hCC, 8'h00, 2'b01, 12'd3, 12'd0, 1'b1, 1'b1, 8'hCC, 1'b1, 12'd3, 2'b01, 1'b0, 1'b1};
        tbl[4]  = '{2'b10, 8'h00, 8'h11, 2'b10, 12'd0, 12'd1, 1'b1, 1'b0, 8'h00, 1'b0, 12'd0, 2'b00, 1'b0, 1'b1};
        tbl[5]  = tbl[4];
        tbl[6]  = tbl[4];
        tbl[7]  = tbl[4];
        tbl[8]  = '{2'b10, 8'h00, 8'h11, 2'b10, 12'd0, 12'd1, 1'b1, 1'b0, 8'h00, 1'b0, 12'd0, 2'b00, 1'b0, 1'b0};
        tbl[9]  = '{2'b10, 8'h00, 8'h11, 2'b10, 12'd0, 12'd1, 1'b1, 1'b1, 8'h11, 1'b1, 12'd1, 2'b10, 1'b1, 1'b1};
        tbl[10] = '{2'b00, 8'h00, 8'h00, 2'b00, 12'd0, 12'd0, 1'b1, 1'b0, 8'h00, 1'b0, 12'd0, 2'b00, 1'b1, 1'b1};
        do_reset();
        for (int i = 0; i < 11; i++) begin
            @(posedge clk);
            #1;
            s_tvalid = tbl[i].v; s_tdata = {tbl[i].d1, tbl[i].d0}; s_tlast = tbl[i].l;
            s_tuser = {tbl[i].u1, tbl[i].u0}; m_tready = tbl[i].mr;
            @(negedge clk);
            chk($sformatf("tbl[%0d] m_tvalid", i), 32'(m_tvalid), 32'(tbl[i].ev));
            chk($sformatf("tbl[%0d] m_tdata", i),  32'(m_tdata),  32'(tbl[i].ed));
            chk($sformatf("tbl[%0d] m_tlast", i),  32'(m_tlast),  32'(tbl[i].el));
            chk($sformatf("tbl[%0d] m_tuser", i),  32'(m_tuser),  32'(tbl[i].eu));
            chk($sformatf("tbl[%0d] s_tready", i), 32'(s_tready), 32'(tbl[i].er));
            chk($sformatf("tbl[%0d] grant", i),    32'(grant),    32'(tbl[i].eg));
            chk($sformatf("tbl[%0d] busy", i),     32'(busy),     32'(tbl[i].eb));
        end

        // ---- granted src1 stalls mid-packet while src0 waits ----
        do_reset();
        @(posedge clk); #1;
        s_tvalid = 2'b10; s_tdata[15:8] = 8'h41; s_tlast = 2'b00; s_tuser[23:12] = 12'd2; m_tready = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        chk("stall first beat", 32'(m_tdata), 32'h41);
        @(posedge clk); #1;
        s_tvalid = 2'b01; s_tdata[7:0] = 8'h30; s_tlast = 2'b01; s_tuser[11:0] = 12'd1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            chk("stall grant held",   32'(grant),    32'd1);
            chk("stall m_tvalid low", 32'(m_tvalid), 32'd0);
            chk("stall s_tready",     32'(s_tready), 32'b10);
            @(posedge clk); #1;
        end
        s_tvalid = 2'b11; s_tdata[15:8] = 8'h42; s_tlast = 2'b11;
        @(negedge clk);
        chk("stall last beat", 32'({grant, m_tlast, m_tdata}), 32'({1'b1, 1'b1, 8'h42}));
        @(posedge clk); #1;
        s_tvalid = 2'b01;
        idle = 0; found = 1'b0;
        for (int c = 0; c < 20 && !found; c++) begin
            @(negedge clk);
            if (m_tvalid) begin
                found = 1'b1;
            end else begin
                idle++;
                @(posedge clk); #1;
            end
        end
        chk("stall src0 served",  32'(found), 32'd1);
        chk("stall idle cycles",  32'(idle), 32'(GAP + 1));
        chk("stall src0 grant",   32'({grant, m_tdata}), 32'({1'b0, 8'h30}));

        // ---- GAP_CYCLES=0 build: single-beat packets alternate ----
        do_reset();
        @(posedge clk); #1;
        g0_tvalid = 2'b11; g0_tdata = 16'h6150; g0_tlast = 2'b11; g0_tuser = 24'h001001; g0_mready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk($sformatf("g0 cyc%0d m_tvalid", i), 32'(g0_mvalid), 32'(i % 2));
            if (i % 2 == 1) begin
                chk($sformatf("g0 cyc%0d grant", i), 32'(g0_grant), 32'(((i - 1) / 2) % 2));
                chk($sformatf("g0 cyc%0d data", i),  32'(g0_mdata), (((i - 1) / 2) % 2 == 1) ? 32'h61 : 32'h50);
            end
            @(posedge clk); #1;
        end
        g0_tvalid = 2'b00;

        // ---- reset asserted during beat 2 of 5 ----
        do_reset();
        @(posedge clk); #1;
        s_tvalid = 2'b01; s_tdata[7:0] = 8'h01; s_tlast = 2'b01; s_tuser[11:0] = 12'd1; m_tready = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        s_tvalid = 2'b00;
        repeat (6) @(posedge clk);
        #1;
        s_tvalid = 2'b01; s_tdata[7:0] = 8'h10; s_tlast = 2'b00; s_tuser[11:0] = 12'd5;
        @(posedge clk); #1;
        @(posedge clk); #1;
        s_tvalid = 2'b11; s_tdata = 16'h7711; s_tlast = 2'b10; s_tuser[23:12] = 12'd1;
        @(negedge clk);
        chk("rstmid beat2 shown", 32'({m_tvalid, m_tdata}), 32'({1'b1, 8'h11}));
        rst = 1'b1;
        #1;
        chk("rstmid m_tvalid", 32'(m_tvalid), 32'd0);
        chk("rstmid s_tready", 32'(s_tready), 32'd0);
        chk("rstmid busy",     32'(busy),     32'd0);
        chk("rstmid grant",    32'(grant),    32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        chk("rstmid regrant src0", 32'({grant, m_tvalid, m_tdata}), 32'({1'b0, 1'b1, 8'h11}));

        // ---- randomized packets vs packet-level round-robin model ----
        do_reset();
        npkt[0] = $urandom_range(3, 6);
        npkt[1] = $urandom_range(1, 6);
        for (int k = 0; k < NSRC; k++) begin
            for (int p = 0; p < npkt[k]; p++) begin
                plen[k][p] = (k == 0 && p == 0) ? 16 : $urandom_range(1, 16);
                for (int b = 0; b < 16; b++) pd[k][p][b] = 8'($urandom);
            end
            rem[k] = npkt[k]; cp[k] = 0; cb[k] = 0; vl[k] = 1'b1;
        end
        last = NSRC - 1;
        for (int n = 0; n < npkt[0] + npkt[1]; n++) begin
            s = last;
            do s = (s + 1) % NSRC; while (rem[s] == 0);
            for (int b = 0; b < plen[s][npkt[s] - rem[s]]; b++) begin
                e.src = s;
                e.d   = pd[s][npkt[s] - rem[s]][b];
                e.l   = (b == plen[s][npkt[s] - rem[s]] - 1);
                e.u   = 12'(plen[s][npkt[s] - rem[s]]);
                exp_q.push_back(e);
            end
            rem[s]--;
            last = s;
        end
        drive_src();
        m_tready = ($urandom_range(0, 3) != 0);
        tracking = 1'b0; gap_n = 0;
        for (int cyc = 0; cyc < 4000 && exp_q.size() > 0; cyc++) begin
            @(negedge clk);
            chk("rand nongrant tready", 32'(s_tready & ~(2'b01 << grant)), 32'd0);
            if (tracking) begin
                if (m_tvalid) begin
                    chk("rand gap length", 32'(gap_n), 32'(GAP + 1));
                    tracking = 1'b0;
                end else begin
                    gap_n++;
                    chk("rand busy in gap", 32'(busy), 32'(gap_n <= GAP));
                end
            end
            if (m_tvalid && m_tready) begin
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    chk("rand beat", 32'({grant, m_tlast, m_tuser, m_tdata}), 32'({e.src[0], e.l, e.u, e.d}));
                    if (m_tlast && exp_q.size() > 0) begin
                        tracking = 1'b1;
                        gap_n    = 0;
                    end
                end else begin
                    chk("rand extra beat", 32'({grant, m_tlast, m_tuser, m_tdata}), 32'hFFFF_FFFF);
                end
            end
            for (int k = 0; k < NSRC; k++) xfer[k] = s_tvalid[k] && s_tready[k];
            @(posedge clk); #1;
            for (int k = 0; k < NSRC; k++) begin
                if (xfer[k]) begin
                    cb[k]++;
                    if (cb[k] == plen[k][cp[k]]) begin
                        cp[k]++;
                        cb[k] = 0;
                    end
                    vl[k] = (cb[k] == 0) ? 1'b1 : ($urandom_range(0, 3) != 0);
                end else if (!vl[k]) begin
                    vl[k] = ($urandom_range(0, 1) != 0);
                end
            end
            drive_src();
            m_tready = ($urandom_range(0, 3) != 0);
        end
        chk("rand all beats delivered", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
